// File: rtl/somador_pkg.sv
`default_nettype none
// ============================================================================
// Module  : somador_pkg
// Brief   : Shared state encoding and default width for the serial adder.
// Revision: 1.0 - initial release
// ============================================================================
package somador_pkg;

    localparam int C_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/somador_completo.sv
`default_nettype none
// ============================================================================
// Module  : somador_completo
// Brief   : Combinational one-bit full adder cell.
// Revision: 1.0 - initial release
// ============================================================================
module somador_completo (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout
);

    assign S    = A ^ B ^ Cin;
    assign Cout = (A & B) | (A & Cin) | (B & Cin);

endmodule
`default_nettype wire

// File: rtl/somador_serial.sv
`default_nettype none
// ============================================================================
// Module  : somador_serial
// Brief   : Bit-serial LSB-first ripple adder with registered carry; parallel
//           load on start, parallel result with a one-cycle done pulse.
// Revision: 1.0 - initial release
// ============================================================================
module somador_serial
    import somador_pkg::*;
#(
    parameter int WIDTH = C_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int                  C_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [C_CNT_W-1:0]  C_LAST  = C_CNT_W'(WIDTH - 1);

    state_t             r_state;
    state_t             w_next;
    logic               w_accept;
    logic               w_last;
    logic               w_s;
    logic               w_c;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry;
    logic [C_CNT_W-1:0] r_cnt;
    logic               r_cout;
    logic               r_ovf;

    assign w_last = (r_cnt == C_LAST);

    somador_completo u_fa (
        .A    (r_a[0]),
        .B    (r_b[0]),
        .Cin  (r_carry),
        .S    (w_s),
        .Cout (w_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        busy     = 1'b0;
        done     = 1'b0;
        w_accept = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done = 1'b1;
                // start in DONE chains straight into the next operation
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = ST_RUN;
                end else begin
                    w_next   = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (r_state == ST_RUN) begin
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_sum   <= {w_s, r_sum[WIDTH-1:1]};
            r_carry <= w_c;
            if (w_last) begin
                r_cout <= w_c;
                // carry into the MSB differs from carry out -> signed overflow
                r_ovf  <= r_carry ^ w_c;
            end else begin
                r_cnt  <= r_cnt + C_CNT_W'(1);
            end
        end
    end

    assign result = r_sum;
    assign cout   = r_cout;
    assign ovf    = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_somador_serial.sv
`default_nettype none
// ============================================================================
// Module  : tb_somador_serial
// Brief   : Self-checking bench for somador_serial (WIDTH=4) against an
//           arithmetic reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_somador_serial;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;

    int total;
    int bad;
    int done_cnt;

    somador_serial #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .ovf    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // {ovf, cout, sum} from plain integer arithmetic
    function automatic logic [W+1:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y);
        int u, sx, sy, ss;
        logic [W-1:0] s;
        u  = int'(x) + int'(y);
        s  = W'(u);
        sx = x[W-1] ? int'(x) - (1 << W) : int'(x);
        sy = y[W-1] ? int'(y) - (1 << W) : int'(y);
        ss = sx + sy;
        return {(ss > (1 << (W-1)) - 1) || (ss < -(1 << (W-1))), u >= (1 << W), s};
    endfunction

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (!done) check({tag, "_timeout"}, 0, 1);
    endtask

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input string tag);
        int n, nb, d0;
        logic [W+1:0] e;
        e = ref_add(x, y);
        @(negedge clk);
        a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = W'($urandom); b = W'($urandom);
        n = 0; nb = 0; d0 = done_cnt;
        while (!done && n < 40) begin
            if (busy) nb++;
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_latency"}, n, W);
        check({tag, "_busy_cycles"}, nb, W);
        check({tag, "_result"}, result, e[W-1:0]);
        check({tag, "_cout"}, cout, e[W]);
        check({tag, "_ovf"}, ovf, e[W+1]);
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_done_count"}, done_cnt - d0, 1);
        check({tag, "_held"}, {ovf, cout, result}, e);
    endtask

    initial begin
        int d0;
        total = 0; bad = 0; done_cnt = 0;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_outs", {ovf, cout, result}, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_busy", busy, 0);

        // directed cases with hand-computed results
        run_op(4'b0011, 4'b0101, "add_3_5");
        check("d_3_5", {ovf, cout, result}, {1'b1, 1'b0, 4'b1000});
        run_op(4'hF, 4'h1, "add_15_1");
        check("d_15_1", {ovf, cout, result}, {1'b0, 1'b1, 4'h0});
        run_op(4'b1000, 4'b1000, "add_m8_m8");
        check("d_m8_m8", {ovf, cout, result}, {1'b1, 1'b1, 4'h0});
        run_op(4'b0111, 4'b1000, "add_7_m8");
        check("d_7_m8", {ovf, cout, result}, {1'b0, 1'b0, 4'b1111});

        // start during RUN must be ignored
        @(negedge clk); a = 4'd3; b = 4'd5; start = 1'b1;
        @(posedge clk); #1; start = 1'b0; d0 = done_cnt;
        @(posedge clk); #1; start = 1'b1; a = 4'd9; b = 4'd9;
        @(posedge clk); #1; start = 1'b0;
        wait_done("ign");
        check("ign_result", {ovf, cout, result}, {1'b1, 1'b0, 4'b1000});
        @(posedge clk); #1;
        check("ign_done_count", done_cnt - d0, 1);
        check("ign_idle", {busy, done}, 0);

        // start held through DONE chains a second operation
        @(negedge clk); a = 4'd1; b = 4'd2; start = 1'b1;
        @(posedge clk); #1;
        wait_done("b2b1");
        check("b2b1_result", result, 3);
        a = 4'd4; b = 4'd5;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b_busy", busy, 1);
        check("b2b_done_low", done, 0);
        wait_done("b2b2");
        check("b2b2_result", {ovf, cout, result}, {1'b1, 1'b0, 4'd9});
        @(posedge clk); #1;

        // asynchronous reset mid-RUN with a non-zero held result
        run_op(4'd7, 4'd6, "pre_abort");
        @(negedge clk); a = 4'd6; b = 4'd6; start = 1'b1;
        @(posedge clk); #1; start = 1'b0; d0 = done_cnt;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_outs", {ovf, cout, result}, 0);
        repeat (6) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("abort_no_done", done_cnt - d0, 0);
        run_op(4'd2, 4'd2, "add_2_2");
        check("d_2_2", {ovf, cout, result}, {1'b0, 1'b0, 4'b0100});

        // randomized operands against the arithmetic model
        for (int i = 0; i < 24; i++) begin
            run_op(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
